// File: rtl/or_16bit_stream_chip_if.sv
// or_16bit_stream_chip_if: operand-pair input stream and OR-result output stream, both valid/ready.
interface or_16bit_stream_chip_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/or_16bit_stream_chip.sv
// or_16bit_stream_chip: small operand-pair FIFO whose head entry drives a combinational 16-bit OR chip.
module or_16bit_chip (
    output logic [15:0] out,
    input  logic [15:0] a,
    input  logic [15:0] b
);
    assign out = a | b;
endmodule

module or_16bit_stream_chip #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    or_16bit_stream_chip_if.slave s,
    output logic [PTR_W:0]        level,
    output logic [15:0]           xfer_count
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    logic [15:0]      r_a [DEPTH];
    logic [15:0]      r_b [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_level;
    logic [15:0]      r_xfer;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W:0]   w_level_nxt;
    logic [15:0]      w_or;
    // Handshake flags depend on registered level only, so no in->out combinational path exists.
    assign s.in_ready  = r_level != FULL;
    assign s.out_valid = r_level != '0;
    assign w_push      = s.in_valid && s.in_ready;
    assign w_pop       = s.out_valid && s.out_ready;
    assign level       = r_level;
    assign xfer_count  = r_xfer;
    always_comb begin
        w_level_nxt = (w_push == w_pop) ? r_level :
                      w_push            ? r_level + (PTR_W + 1)'(1) :
                                          r_level - (PTR_W + 1)'(1);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else if (w_push) begin
            r_a[r_wptr] <= s.in_a;
            r_b[r_wptr] <= s.in_b;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_xfer  <= '0;
        end else begin
            r_level <= w_level_nxt;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
                r_xfer <= r_xfer + 16'd1;
            end
        end
    end
    or_16bit_chip u_or (
        .out (w_or),
        .a   (r_a[r_rptr]),
        .b   (r_b[r_rptr])
    );
    assign s.out_data = w_or;
endmodule

// File: tb/tb_or_16bit_stream_chip.sv
// tb_or_16bit_stream_chip: vector table, directed corner sequences and random traffic against a queue model.
module tb_or_16bit_stream_chip;
    localparam int DEPTH = 2;
    localparam int PTR_W = 1;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [PTR_W:0] level;
    logic [15:0] xfer_count;
    int total = 0;
    int bad = 0;
    logic [15:0] mq[$];
    logic [15:0] mx = 16'd0;
    bit chk_on = 1'b1;

    or_16bit_stream_chip_if bus ();
    or_16bit_stream_chip #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s          (bus),
        .level      (level),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [15:0] a;
        logic [15:0] b;
        logic        ordy;
        logic [2:0]  lvl;
        logic        ov;
        logic        ir;
        logic [15:0] dat;
        logic [15:0] xf;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic check_state(input string n);
        chk({n, ".level"}, 32'(level), 32'(mq.size()));
        chk({n, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
        chk({n, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() != DEPTH));
        chk({n, ".xfer_count"}, 32'(xfer_count), 32'(mx));
        if (mq.size() != 0) chk({n, ".out_data"}, 32'(bus.out_data), 32'(mq[0]));
    endtask

    // Model decides accept/pop from queue occupancy before the edge, then the DUT is compared after it.
    task automatic cyc(input string n, input logic iv, input logic [15:0] a, input logic [15:0] b, input logic ordy);
        logic mpush;
        logic mpop;
        logic [15:0] d;
        bus.in_valid  = iv;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ordy;
        mpush = iv && (mq.size() < DEPTH);
        mpop  = ordy && (mq.size() > 0);
        if (mpop) begin
            d = mq.pop_front();
            mx = mx + 16'd1;
        end
        if (mpush) mq.push_back(a | b);
        @(posedge clk);
        #1;
        if (chk_on) check_state(n);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst0.level", 32'(level), 0);
        chk("rst0.out_valid", 32'(bus.out_valid), 0);
        chk("rst0.in_ready", 32'(bus.in_ready), 1);
        chk("rst0.xfer", 32'(xfer_count), 0);
        chk("rst0.out_data", 32'(bus.out_data), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        tbl[0] = '{1'b1, 16'h0000, 16'hFFFF, 1'b1, 3'd1, 1'b1, 1'b1, 16'hFFFF, 16'd0};
        tbl[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b1, 16'h0000, 16'd1};
        tbl[2] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 3'd1, 1'b1, 1'b1, 16'hFFFF, 16'd1};
        tbl[3] = '{1'b1, 16'hA38C, 16'hC707, 1'b0, 3'd2, 1'b1, 1'b0, 16'hFFFF, 16'd1};
        tbl[4] = '{1'b1, 16'h0001, 16'h0002, 1'b0, 3'd2, 1'b1, 1'b0, 16'hFFFF, 16'd1};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 3'd1, 1'b1, 1'b1, 16'hE78F, 16'd2};
        tbl[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b1, 16'h0000, 16'd3};
        tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b1, 16'h0000, 16'd3};
        for (int i = 0; i < 8; i++) begin
            bus.in_valid  = tbl[i].iv;
            bus.in_a      = tbl[i].a;
            bus.in_b      = tbl[i].b;
            bus.out_ready = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d.xfer", i), 32'(xfer_count), 32'(tbl[i].xf));
            if (tbl[i].ov) chk($sformatf("tbl%0d.out_data", i), 32'(bus.out_data), 32'(tbl[i].dat));
        end
        mx = 16'd3;

        cyc("mid.push0", 1'b1, 16'h1234, 16'h00F0, 1'b0);
        cyc("mid.push1", 1'b1, 16'h8001, 16'h0110, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        chk("rst1.level", 32'(level), 0);
        chk("rst1.out_valid", 32'(bus.out_valid), 0);
        chk("rst1.in_ready", 32'(bus.in_ready), 1);
        chk("rst1.xfer", 32'(xfer_count), 0);
        chk("rst1.out_data", 32'(bus.out_data), 0);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst1.hold.xfer", 32'(xfer_count), 0);
        chk("rst1.hold.level", 32'(level), 0);
        reset_n = 1'b1;
        mq.delete();
        mx = 16'd0;

        cyc("pp.prime", 1'b1, 16'($urandom), 16'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) cyc($sformatf("pp%0d", i), 1'b1, 16'($urandom), 16'($urandom), 1'b1);
        chk("pp.xfer", 32'(xfer_count), 8);
        cyc("pp.drain", 1'b0, 16'h0, 16'h0, 1'b1);

        for (int r = 0; r < 5; r++) begin
            cyc($sformatf("wrap%0d.f0", r), 1'b1, 16'($urandom), 16'($urandom), 1'b0);
            cyc($sformatf("wrap%0d.f1", r), 1'b1, 16'($urandom), 16'($urandom), 1'b0);
            cyc($sformatf("wrap%0d.d0", r), 1'b0, 16'($urandom), 16'($urandom), 1'b1);
            cyc($sformatf("wrap%0d.d1", r), 1'b0, 16'($urandom), 16'($urandom), 1'b1);
        end

        for (int i = 0; i < 300; i++)
            cyc("rand", 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        if (mq.size() == 0) cyc("xw.prime", 1'b1, 16'($urandom), 16'($urandom), 1'b0);
        chk_on = 1'b0;
        for (int k = 0; k < 70000 && mx != 16'hFFFF; k++)
            cyc("xw.run", 1'b1, 16'($urandom), 16'($urandom), 1'b1);
        chk_on = 1'b1;
        chk("xw.pre", 32'(xfer_count), 32'h0000FFFF);
        check_state("xw.pre");
        cyc("xw.wrap", 1'b1, 16'h5A00, 16'h00A5, 1'b1);
        chk("xw.zero", 32'(xfer_count), 0);
        for (int i = 0; i < 40; i++)
            cyc("xw.after", 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/or_16bit_stream_chip.md
Name: or_16bit_stream_chip

Overview:
Operand staging stage that sits directly upstream of or_16bit_chip. It buffers incoming 16-bit operand pairs (a, b) behind a valid/ready handshake in a small FIFO. The head pair drives an internal or_16bit_chip instance, port order (out, a, b), and the OR result is presented downstream with its own valid/ready handshake. This lets the combinational OR chip run in a back-pressured data stream.

Parameters:
DEPTH, 2, number of operand-pair FIFO entries; power of two, legal range 2..16.
PTR_W, 1, pointer width, equal to log2(DEPTH); set together with DEPTH.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents a valid operand pair
in_ready  output  1  stage can accept a pair this cycle
in_a  input  16  operand a
in_b  input  16  operand b
out_valid  output  1  out_data holds a valid OR result
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  16  bitwise OR of the head entry's a and b
level  output  PTR_W+1  current number of stored pairs, 0..DEPTH
xfer_count  output  16  count of completed output transfers, wraps at 16 bits

Behaviour:
- Reset: asynchronous assertion when reset_n goes low; release is synchronous to clk. While in reset, all state clears immediately:
  - level=0, out_valid=0, in_ready=1, xfer_count=0, read/write pointers=0.
  - out_data=16'h0000, because the head storage entry is cleared.
- Reset mid-stream discards all stored pairs. No output transfer completes in the cycle reset is asserted.
- Push occurs on a rising edge with in_valid && in_ready. The pair is written at the write pointer; the write pointer increments modulo DEPTH.
- Pop occurs on a rising edge with out_valid && out_ready. The read pointer increments modulo DEPTH and xfer_count increments (16'hFFFF wraps to 16'h0000).
- in_ready = (level != DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
- out_valid = (level != 0). There is no combinational path from in_valid.
- out_data is the combinational output of the internal or_16bit_chip, driven by the entry at the read pointer. It must be bit-exact: out_data[i] = a[i] | b[i] for all 16 bits.
- Latency: a pair accepted at edge N appears with out_valid=1 immediately after edge N. That is one cycle of latency, with no bypass in the same cycle.
- level update:
  - push only: +1
  - pop only: -1
  - push and pop on the same edge: unchanged, with both pointers advancing.
- Full (level=DEPTH): in_ready=0, and in_valid is ignored with no overwrite. A pop on that edge makes in_ready=1 from the next cycle.
- Empty (level=0): out_valid=0, and out_ready is ignored; xfer_count does not change.
- Upstream holding in_valid with changing data while in_ready=0 is legal. Only data present on the accepting edge is stored.
- Ordering is strictly FIFO; pairs are never reordered or duplicated.
- Values of out_data while out_valid=0 are don't-care for the bench, except after reset, when out_data must be 0.

Test Plan:
- Reset: drive reset_n=0 asynchronously mid-cycle with 2 pairs stored -> level=0, out_valid=0, in_ready=1, xfer_count=0, out_data=16'h0000 immediately, before the next clk edge.
- Single pass-through, out_ready=1: push a=16'b0000000000000000, b=16'b1111111111111111 -> next cycle out_valid=1, out_data=16'hFFFF; after the pop edge, level=0 and xfer_count=1.
- Fill and stall, out_ready=0: push (16'hFFFF, 16'h0000) then (16'b1010001110001100, 16'b1100011100000111) -> level=2, in_ready=0; a third push of (16'h0001, 16'h0002) is dropped. Then raise out_ready -> outputs appear in order 16'hFFFF, then 16'b1110011110001111, and nothing further.
- Simultaneous push and pop at level=1 for 8 consecutive cycles with in_valid=1, out_ready=1 -> level stays 1, each output equals the OR of the pair pushed one cycle earlier, xfer_count advances by 8.
- Pointer wrap with DEPTH=2: 5 fill/drain cycles of 2 pairs each, using random operands -> all 10 outputs match a|b in order, and level never exceeds 2.
- xfer_count wrap: preload by running 65535 transfers, then do one more -> xfer_count=16'h0000 and the stream still behaves correctly.
